// File: rtl/lsu.sv
// lsu: load/store unit; checks each op, drives one bus request, and returns a load result, a store completion or an exception.
module lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_is_store,
  input  logic [2:0]          ex_funct3,
  input  logic [XLEN-1:0]     ex_addr,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic [4:0]          ex_rd,
  output logic [ADDR_LEN-1:0] addr,
  output logic                rd_req,
  input  logic                rd_ready,
  output logic                wr_req,
  input  logic                wr_ready,
  output logic [XLEN/8-1:0]   be,
  output logic [XLEN-1:0]     wr_data,
  input  logic [XLEN-1:0]     rd_data,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                st_done,
  output logic                exc_valid,
  output logic [1:0]          exc_cause,
  output logic [XLEN-1:0]     exc_addr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int NB = XLEN / 8;
  typedef enum logic [2:0] {IDLE, CHK, RD, WR, RESP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic st_q;
  logic [2:0] f3_q;
  logic [XLEN-1:0] ea_q, wr_data_q, wb_data_q, exc_addr_q, s, ld;
  logic [ADDR_LEN-1:0] addr_q;
  logic [4:0] wb_rd_q;
  logic exc_valid_q, exc_d, illegal, mis, bad, rdy, tmo;
  logic [1:0] exc_cause_q, cause_d;
  assign illegal = (f3_q inside {3'b011, 3'b110, 3'b111}) || (st_q && f3_q[2]);
  assign mis = (f3_q[1:0] == 2'b01 && ea_q[0]) || (f3_q[1:0] == 2'b10 && ea_q[1:0] != 2'b00);
  assign bad = illegal || mis;
  assign rdy = (state_q == RD) ? rd_ready : wr_ready;
  // Ready in the limit cycle still completes; only a missing ready at the limit times out.
  assign tmo = !rdy && cnt_q == CW'(TIMEOUT - 1);
  assign s = rd_data >> {ea_q[1:0], 3'b000};
  assign ld = f3_q[1:0] == 2'b00 ? {{(XLEN-8){s[7] & ~f3_q[2]}}, s[7:0]} :
              f3_q[1:0] == 2'b01 ? {{(XLEN-16){s[15] & ~f3_q[2]}}, s[15:0]} : rd_data;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    exc_d = 1'b0;
    cause_d = 2'd2;
    case (state_q)
      IDLE: state_d = ex_valid ? CHK : IDLE;
      CHK: begin
        state_d = bad ? IDLE : st_q ? WR : RD;
        cnt_d = '0;
        exc_d = bad;
        cause_d = illegal ? 2'd3 : {1'b0, st_q};
      end
      RD, WR: begin
        state_d = rdy ? RESP : tmo ? IDLE : state_q;
        cnt_d = cnt_q + CW'(1);
        exc_d = tmo;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q <= '0;
      st_q <= 1'b0;
      f3_q <= '0;
      ea_q <= '0;
      addr_q <= '0;
      wr_data_q <= '0;
      wb_data_q <= '0;
      wb_rd_q <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      exc_valid_q <= exc_d;
      if (exc_d) begin
        exc_cause_q <= cause_d;
        exc_addr_q <= ea_q;
      end
      if (state_q == IDLE && ex_valid) begin
        st_q <= ex_is_store;
        f3_q <= ex_funct3;
        ea_q <= ex_addr;
        addr_q <= ex_addr[ADDR_LEN-1:0];
        wb_rd_q <= ex_rd;
        wr_data_q <= ex_funct3[1:0] == 2'b00 ? {NB{ex_wdata[7:0]}} :
                     ex_funct3[1:0] == 2'b01 ? {(XLEN/16){ex_wdata[15:0]}} : ex_wdata;
      end
      if (state_q == RD && rd_ready) wb_data_q <= ld;
    end
  end
  assign ex_ready = state_q == IDLE;
  assign rd_req = state_q == RD;
  assign wr_req = state_q == WR;
  assign be = state_q != WR ? '0 :
              f3_q[1:0] == 2'b00 ? NB'(1) << ea_q[1:0] :
              f3_q[1:0] == 2'b01 ? NB'(3) << ea_q[1:0] : '1;
  assign wb_valid = state_q == RESP && !st_q;
  assign st_done = state_q == RESP && st_q;
  assign addr = addr_q;
  assign wr_data = wr_data_q;
  assign wb_data = wb_data_q;
  assign wb_rd = wb_rd_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr = exc_addr_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu; a responder models bus latency and a monitor checks every completion pulse.
module tb_lsu;
  logic clk = 1'b0;
  logic rstb, ex_valid, ex_ready, ex_is_store;
  logic [2:0] ex_funct3;
  logic [31:0] ex_addr, ex_wdata, wr_data, rd_data, wb_data, exc_addr;
  logic [4:0] ex_rd, wb_rd;
  logic [13:0] addr;
  logic rd_req, wr_req, wb_valid, st_done, exc_valid;
  logic rd_ready = 1'b0;
  logic wr_ready = 1'b0;
  logic [3:0] be;
  logic [1:0] exc_cause;
  typedef struct {
    int kind;
    logic [31:0] d;
    logic [4:0] rd;
    logic [1:0] cause;
    logic [3:0] be;
    logic [31:0] wd;
    logic [13:0] a;
    int t0;
    int lat;
    int rq;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, rq_n = 0, lat_r = 1, lat_w = 0, wcnt = 0, rd_viol = 0;

  lsu dut (
    .clk(clk), .rstb(rstb), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .addr(addr),
    .rd_req(rd_req), .rd_ready(rd_ready), .wr_req(wr_req), .wr_ready(wr_ready), .be(be),
    .wr_data(wr_data), .rd_data(rd_data), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstb) rq_n <= 0;
    else if (wb_valid || st_done || exc_valid) rq_n <= 0;
    else if (rd_req) rq_n <= rq_n + 1;
  end

  // Ready is raised after lat_r/lat_w waiting cycles of an asserted request.
  always @(negedge clk) begin
    if (rd_req && rd_ready) rd_viol++;
    if (rd_req || wr_req) begin
      rd_ready = rd_req && (wcnt == lat_r);
      wr_ready = wr_req && (wcnt == lat_w);
      wcnt++;
    end else begin
      rd_ready = 1'b0;
      wr_ready = 1'b0;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_req && q.size() > 0) chk("rd_addr", addr, q[0].a);
    if (wr_req && q.size() > 0) begin
      chk("wr_addr", addr, q[0].a);
      chk("be", be, q[0].be);
      chk("wr_data", wr_data, q[0].wd);
    end
    if (wb_valid || st_done || exc_valid) begin
      chk("one_pulse", 32'(wb_valid) + 32'(st_done) + 32'(exc_valid), 1);
      chk("be_idle", be, 0);
      chk("pulse_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("kind", wb_valid ? 0 : st_done ? 1 : 2, e.kind);
        if (e.kind == 0) begin
          chk("wb_data", wb_data, e.d);
          chk("wb_rd", wb_rd, e.rd);
        end
        if (e.kind == 2) begin
          chk("exc_cause", exc_cause, e.cause);
          chk("exc_addr", exc_addr, e.d);
        end
        if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
        if (e.rq >= 0) chk("rd_req_cycles", rq_n, e.rq);
      end
    end
  end

  task automatic op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] rd, input int kind, input logic [31:0] d, input logic [1:0] cause,
                    input logic [3:0] bee, input logic [31:0] wde, input int lat, input int rq);
    @(negedge clk);
    ex_valid = 1'b1;
    ex_is_store = st;
    ex_funct3 = f3;
    ex_addr = a;
    ex_wdata = wd;
    ex_rd = rd;
    for (int i = 0; i < 1000 && !ex_ready; i++) @(negedge clk);
    chk("accept", ex_ready, 1);
    q.push_back('{kind: kind, d: d, rd: rd, cause: cause, be: bee, wd: wde, a: a[13:0],
                  t0: cyc, lat: lat, rq: rq});
    @(negedge clk);
    chk("busy", ex_ready, 0);
  endtask

  task automatic ld_op(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                       input logic [31:0] d, input int lat, input int rq);
    op(1'b0, f3, a, 32'h0, rd, 0, d, 2'd0, 4'h0, 32'h0, lat, rq);
  endtask

  task automatic st_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] bee, input logic [31:0] wde);
    op(1'b1, f3, a, wd, 5'd0, 1, 32'h0, 2'd0, bee, wde, 3, 0);
  endtask

  task automatic exc_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [1:0] cause, input int rq);
    op(st, f3, a, 32'h1111_2222, 5'd3, 2, a, cause, 4'h0, 32'h0, -1, rq);
  endtask

  task automatic drain();
    ex_valid = 1'b0;
    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0;
    ex_valid = 1'b0;
    ex_is_store = 1'b0;
    ex_funct3 = 3'b000;
    ex_addr = 32'h0;
    ex_wdata = 32'h0;
    ex_rd = 5'd0;
    rd_data = 32'h80FF_1234;
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_be", be, 0);
    chk("rst_pulses", {wb_valid, st_done, exc_valid}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_exc", {exc_cause, exc_addr[29:0]}, 0);
    chk("rst_wb_rd", wb_rd, 0);
    rstb = 1'b1;
    ld_op(3'b000, 32'h4003, 5'd5, 32'hFFFF_FF80, 4, 2); drain();
    ld_op(3'b100, 32'h4003, 5'd6, 32'h0000_0080, 4, 2); drain();
    ld_op(3'b001, 32'h4002, 5'd7, 32'hFFFF_80FF, 4, 2); drain();
    ld_op(3'b101, 32'h4002, 5'd8, 32'h0000_80FF, 4, 2); drain();
    ld_op(3'b010, 32'h4000, 5'd9, 32'h80FF_1234, 4, 2); drain();
    ld_op(3'b000, 32'h4000, 5'd10, 32'h0000_0034, 4, 2); drain();
    ld_op(3'b000, 32'h4001, 5'd11, 32'h0000_0012, 4, 2); drain();
    ld_op(3'b001, 32'h4000, 5'd12, 32'h0000_1234, 4, 2); drain();
    rd_data = 32'h7F01_8002;
    ld_op(3'b000, 32'h0001, 5'd13, 32'hFFFF_FF80, 4, 2); drain();
    ld_op(3'b001, 32'h0000, 5'd14, 32'hFFFF_8002, 4, 2); drain();
    ld_op(3'b000, 32'h0003, 5'd15, 32'h0000_007F, 4, 2); drain();
    rd_data = 32'h80FF_1234;
    st_op(3'b001, 32'h4002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF); drain();
    st_op(3'b000, 32'h0001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5); drain();
    st_op(3'b001, 32'h0000, 32'hFFFF_1357, 4'b0011, 32'h1357_1357); drain();
    st_op(3'b000, 32'h0003, 32'h0000_007E, 4'b1000, 32'h7E7E_7E7E); drain();
    st_op(3'b010, 32'h0008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF); drain();
    exc_op(1'b0, 3'b010, 32'h4002, 2'd0, 0); drain();
    exc_op(1'b1, 3'b101, 32'h4000, 2'd3, 0); drain();
    exc_op(1'b1, 3'b100, 32'h4000, 2'd3, 0); drain();
    exc_op(1'b1, 3'b010, 32'h4001, 2'd1, 0); drain();
    exc_op(1'b1, 3'b001, 32'h4001, 2'd1, 0); drain();
    exc_op(1'b0, 3'b001, 32'h0003, 2'd0, 0); drain();
    exc_op(1'b0, 3'b011, 32'h0000, 2'd3, 0); drain();
    exc_op(1'b0, 3'b110, 32'h0000, 2'd3, 0); drain();
    exc_op(1'b0, 3'b111, 32'h0001, 2'd3, 0); drain();
    lat_r = 1000;
    exc_op(1'b0, 3'b010, 32'h8000_1000, 2'd2, 255); drain();
    lat_r = 255;
    exc_op(1'b0, 3'b010, 32'h8000_1000, 2'd2, 255); drain();
    lat_r = 254;
    ld_op(3'b010, 32'h8000_1000, 5'd16, 32'h80FF_1234, 257, 255); drain();
    lat_r = 1;
    lat_w = 1000;
    op(1'b1, 3'b010, 32'h10, 32'hA5A5_0F0F, 5'd0, 2, 32'h10, 2'd2, 4'hF, 32'hA5A5_0F0F, -1, 0); drain();
    lat_w = 0;
    lat_r = 1000;
    ld_op(3'b010, 32'h4000, 5'd17, 32'h80FF_1234, -1, -1);
    ex_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_rd_req", rd_req, 1);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    chk("post_reset_rd_req", rd_req, 0);
    chk("post_reset_ex_ready", ex_ready, 1);
    q.delete();
    repeat (3) @(negedge clk);
    lat_r = 1;
    ld_op(3'b010, 32'h4004, 5'd18, 32'h80FF_1234, 4, 2); drain();
    ld_op(3'b000, 32'h4001, 5'd1, 32'h0000_0012, 4, 2);
    st_op(3'b010, 32'h4004, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
    exc_op(1'b0, 3'b010, 32'h4001, 2'd0, 0);
    ld_op(3'b101, 32'h4002, 5'd2, 32'h0000_80FF, 4, 2);
    drain();
    chk("rd_req_after_ready", rd_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
